// File: rtl/ram_dual_port.sv
// -----------------------------------------------------------------------------
// ram_dual_port
//
// Simple dual-port RAM with one write port and one read port on a single
// clock. Used as CPU data memory and as the video/framebuffer backing store.
//
// Features
//   - Independent read and write addresses.
//   - Per-byte write enables.
//   - Selectable same-address read-during-write result:
//     RDW_MODE = 0 returns the old word.
//     RDW_MODE = 1 returns the byte-merged new word.
//   - Read latency of 1 or 2 cycles, qualified by a one-cycle valid strobe.
//   - Hardware clear engine. After reset or on i_Clear it writes CLEAR_VALUE
//     to every word, one word per cycle.
//
// Parameters
//   DEPTH        number of words (power of 2, >= 2)
//   WIDTH        word width in bits (multiple of 8)
//   READ_LATENCY 1 or 2 cycles from read accept to o_Read_Data
//   RDW_MODE     0 = old data, 1 = new data on same-address read/write
//   CLEAR_VALUE  word written by the clear engine
//
// Ports
//   i_CLK            clock, rising edge
//   i_Reset          asynchronous active-high reset
//   i_Clear          start a full clear (honoured only while o_Busy = 0)
//   i_Write_EN       write strobe
//   i_Write_Address  write word address
//   i_Write_Data     write data
//   i_Byte_EN        per-byte write mask; bit k covers bits [8k+7:8k]
//   i_Read_EN        read strobe
//   i_Read_Address   read word address
//   o_Read_Data      registered read data; holds its value between reads
//   o_Read_Valid     one-cycle pulse qualifying o_Read_Data
//   o_Busy           high while the clear engine owns the array
// -----------------------------------------------------------------------------
module ram_dual_port #(
   parameter int               DEPTH        = 16384,
   parameter int               WIDTH        = 16,
   parameter int               READ_LATENCY = 1,
   parameter int               RDW_MODE     = 0,
   parameter logic [WIDTH-1:0] CLEAR_VALUE  = '0
) (
   input  logic                     i_CLK,
   input  logic                     i_Reset,
   input  logic                     i_Clear,
   input  logic                     i_Write_EN,
   input  logic [$clog2(DEPTH)-1:0] i_Write_Address,
   input  logic [WIDTH-1:0]         i_Write_Data,
   input  logic [WIDTH/8-1:0]       i_Byte_EN,
   input  logic                     i_Read_EN,
   input  logic [$clog2(DEPTH)-1:0] i_Read_Address,
   output logic [WIDTH-1:0]         o_Read_Data,
   output logic                     o_Read_Valid,
   output logic                     o_Busy
);

   localparam int ADDR_W    = $clog2(DEPTH);
   localparam int NUM_BYTES = WIDTH / 8;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // Clear engine / port ownership FSM
   // ---------------------------------------------------------------------------
   state_t            r_State;
   logic [ADDR_W-1:0] r_Clear_Count;
   logic              r_Busy;

   always_ff @(posedge i_CLK or posedge i_Reset) begin
      if (i_Reset) begin
         r_State       <= ST_CLEAR;
         r_Clear_Count <= '0;
         r_Busy        <= 1'b1;
      end else begin
         case (r_State)
            ST_CLEAR: begin
               // The counter wraps to 0 after the last word.
               // A later clear therefore starts at address 0 again.
               r_Clear_Count <= r_Clear_Count + ADDR_W'(1);
               if (r_Clear_Count == ADDR_W'(DEPTH - 1)) begin
                  r_State <= ST_READY;
                  r_Busy  <= 1'b0;
               end
            end
            ST_READY: begin
               if (i_Clear) begin
                  r_State       <= ST_CLEAR;
                  r_Clear_Count <= '0;
                  r_Busy        <= 1'b1;
               end
            end
            default: begin
               r_State       <= ST_CLEAR;
               r_Clear_Count <= '0;
               r_Busy        <= 1'b1;
            end
         endcase
      end
   end

   assign o_Busy = r_Busy;

   // ---------------------------------------------------------------------------
   // Write port: the clear engine overrides the user port while clearing
   // ---------------------------------------------------------------------------
   logic                 w_Clearing;
   logic                 w_Ready;
   logic                 w_Read_Accept;
   logic [ADDR_W-1:0]    w_Wr_Addr;
   logic [WIDTH-1:0]     w_Wr_Data;
   logic [NUM_BYTES-1:0] w_Wr_BE;
   logic [WIDTH-1:0]     w_Wr_Bit_Mask;

   assign w_Clearing    = (r_State == ST_CLEAR);
   assign w_Ready       = (r_State == ST_READY);
   assign w_Read_Accept = w_Ready && i_Read_EN;

   assign w_Wr_Addr = w_Clearing ? r_Clear_Count : i_Write_Address;
   assign w_Wr_Data = w_Clearing ? CLEAR_VALUE   : i_Write_Data;
   assign w_Wr_BE   = w_Clearing ? {NUM_BYTES{1'b1}}
                                 : (i_Byte_EN & {NUM_BYTES{i_Write_EN}});

   // User byte mask widened to a bit mask.
   // Only the forwarding path uses it.
   for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bit_mask
      assign w_Wr_Bit_Mask[gi*8 +: 8] = {8{i_Byte_EN[gi]}};
   end

   // ---------------------------------------------------------------------------
   // Storage array. It has no reset so that it can map onto block RAM.
   // The read is registered and happens in the same process as the write.
   // That gives read-first (old data) behaviour on an address collision.
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] r_Mem [DEPTH];
   logic [WIDTH-1:0] r_Ram_Q;

   always_ff @(posedge i_CLK) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
         if (w_Wr_BE[b]) begin
            r_Mem[w_Wr_Addr][b*8 +: 8] <= w_Wr_Data[b*8 +: 8];
         end
      end
      if (w_Read_Accept) begin
         r_Ram_Q <= r_Mem[i_Read_Address];
      end
   end

   // First read stage valid. It is reset so that in-flight reads are dropped.
   logic r_Valid_1;

   always_ff @(posedge i_CLK or posedge i_Reset) begin
      if (i_Reset) begin
         r_Valid_1 <= 1'b0;
      end else begin
         r_Valid_1 <= w_Read_Accept;
      end
   end

   // ---------------------------------------------------------------------------
   // Read-during-write forwarding
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] w_Stage1_Data;

   if (RDW_MODE == 1) begin : g_fwd
      // On a same-address collision, remember which bytes were written and
      // their new values. Those bytes are merged over the old word that the
      // array returns. The registers only change on an accepted read, so the
      // merged word stays stable between reads.
      logic [WIDTH-1:0] r_Fwd_Mask;
      logic [WIDTH-1:0] r_Fwd_Data;
      logic             w_Hit;

      assign w_Hit = i_Write_EN && (i_Write_Address == i_Read_Address);

      always_ff @(posedge i_CLK or posedge i_Reset) begin
         if (i_Reset) begin
            r_Fwd_Mask <= '0;
            r_Fwd_Data <= '0;
         end else if (w_Read_Accept) begin
            r_Fwd_Mask <= w_Hit ? w_Wr_Bit_Mask : '0;
            r_Fwd_Data <= i_Write_Data & w_Wr_Bit_Mask;
         end
      end

      assign w_Stage1_Data = (r_Ram_Q & ~r_Fwd_Mask) | r_Fwd_Data & r_Fwd_Mask;
   end else begin : g_no_fwd
      assign w_Stage1_Data = r_Ram_Q;
   end

   // ---------------------------------------------------------------------------
   // Output stage
   // ---------------------------------------------------------------------------
   if (READ_LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] r_Out_Data;
      logic             r_Valid_2;

      always_ff @(posedge i_CLK or posedge i_Reset) begin
         if (i_Reset) begin
            r_Out_Data <= '0;
            r_Valid_2  <= 1'b0;
         end else begin
            r_Valid_2 <= r_Valid_1;
            if (r_Valid_1) begin
               r_Out_Data <= w_Stage1_Data;
            end
         end
      end

      assign o_Read_Data  = r_Out_Data;
      assign o_Read_Valid = r_Valid_2;
   end else begin : g_lat1
      // The array output register cannot be reset.
      // It is masked to zero until the first read after reset lands.
      logic r_Loaded;

      always_ff @(posedge i_CLK or posedge i_Reset) begin
         if (i_Reset) begin
            r_Loaded <= 1'b0;
         end else if (w_Read_Accept) begin
            r_Loaded <= 1'b1;
         end
      end

      assign o_Read_Data  = r_Loaded ? w_Stage1_Data : '0;
      assign o_Read_Valid = r_Valid_1;
   end

endmodule

// File: tb/tb_ram_dual_port.sv
// -----------------------------------------------------------------------------
// tb_ram_dual_port
//
// Two instances share one stimulus stream:
//   A: READ_LATENCY = 1, RDW_MODE = 0
//   B: READ_LATENCY = 2, RDW_MODE = 1
// Both use DEPTH = 16 and CLEAR_VALUE = 16'hA5A5.
//
// A reference model (word array + queues of pending read responses) predicts
// every output on every cycle. A directed vector table and a few hand-written
// sequences check the specific values expected at the corner cases.
// -----------------------------------------------------------------------------
module tb_ram_dual_port;

   localparam int          DEPTH = 16;
   localparam logic [15:0] CV    = 16'hA5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        we  = 1'b0;
   logic [3:0]  wa  = '0;
   logic [15:0] wd  = '0;
   logic [1:0]  be  = '0;
   logic        re  = 1'b0;
   logic [3:0]  ra  = '0;

   logic [15:0] a_data;
   logic [15:0] b_data;
   logic        a_valid;
   logic        b_valid;
   logic        a_busy;
   logic        b_busy;

   always #5 clk = ~clk;

   ram_dual_port #(
      .DEPTH        (DEPTH),
      .WIDTH        (16),
      .READ_LATENCY (1),
      .RDW_MODE     (0),
      .CLEAR_VALUE  (CV)
   ) u_dut_a (
      .i_CLK           (clk),
      .i_Reset         (rst),
      .i_Clear         (clr),
      .i_Write_EN      (we),
      .i_Write_Address (wa),
      .i_Write_Data    (wd),
      .i_Byte_EN       (be),
      .i_Read_EN       (re),
      .i_Read_Address  (ra),
      .o_Read_Data     (a_data),
      .o_Read_Valid    (a_valid),
      .o_Busy          (a_busy)
   );

   ram_dual_port #(
      .DEPTH        (DEPTH),
      .WIDTH        (16),
      .READ_LATENCY (2),
      .RDW_MODE     (1),
      .CLEAR_VALUE  (CV)
   ) u_dut_b (
      .i_CLK           (clk),
      .i_Reset         (rst),
      .i_Clear         (clr),
      .i_Write_EN      (we),
      .i_Write_Address (wa),
      .i_Write_Data    (wd),
      .i_Byte_EN       (be),
      .i_Read_EN       (re),
      .i_Read_Address  (ra),
      .o_Read_Data     (b_data),
      .o_Read_Valid    (b_valid),
      .o_Busy          (b_busy)
   );

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   typedef struct {
      int          due;
      logic [15:0] d;
   } rd_t;

   logic [15:0] m_mem [DEPTH];
   rd_t         qa[$];
   rd_t         qb[$];
   logic [15:0] last_a = '0;
   logic [15:0] last_b = '0;
   logic        m_busy = 1'b1;
   int          m_idx  = 0;
   int          cyc    = 0;

   function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                         input logic [1:0] mask);
      logic [15:0] r;
      r = old_w;
      for (int b = 0; b < 2; b++) begin
         if (mask[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
      end
      return r;
   endfunction

   task automatic model_reset();
      qa.delete();
      qb.delete();
      last_a = '0;
      last_b = '0;
      m_busy = 1'b1;
      m_idx  = 0;
   endtask

   // Applies the effect of one rising edge, given the inputs held across it.
   task automatic model_edge(input logic c_clr, input logic c_we, input logic [3:0] c_wa,
                             input logic [15:0] c_wd, input logic [1:0] c_be,
                             input logic c_re, input logic [3:0] c_ra);
      rd_t         ea;
      rd_t         eb;
      logic [15:0] old_w;
      cyc++;
      if (m_busy) begin
         m_mem[m_idx] = CV;
         m_idx++;
         if (m_idx == DEPTH) m_busy = 1'b0;
      end else begin
         if (c_re) begin
            old_w  = m_mem[c_ra];
            ea.due = cyc;
            ea.d   = old_w;
            eb.due = cyc + 1;
            eb.d   = (c_we && c_wa == c_ra) ? merge(old_w, c_wd, c_be) : old_w;
            qa.push_back(ea);
            qb.push_back(eb);
         end
         if (c_we) m_mem[c_wa] = merge(m_mem[c_wa], c_wd, c_be);
         if (c_clr) begin
            m_busy = 1'b1;
            m_idx  = 0;
         end
      end
   endtask

   task automatic model_check();
      logic ev_a;
      logic ev_b;
      ev_a = (qa.size() > 0) && (qa[0].due == cyc);
      if (ev_a) begin
         last_a = qa[0].d;
         qa.delete(0);
      end
      ev_b = (qb.size() > 0) && (qb[0].due == cyc);
      if (ev_b) begin
         last_b = qb[0].d;
         qb.delete(0);
      end
      check("model_valid_a", 32'(a_valid), 32'(ev_a));
      check("model_data_a",  32'(a_data),  32'(last_a));
      check("model_valid_b", 32'(b_valid), 32'(ev_b));
      check("model_data_b",  32'(b_data),  32'(last_b));
      check("model_busy_a",  32'(a_busy),  32'(m_busy));
      check("model_busy_b",  32'(b_busy),  32'(m_busy));
   endtask

   // One clock cycle: drive, clock, update model, sample 1 time unit after the edge.
   task automatic step(input logic s_clr, input logic s_we, input logic [3:0] s_wa,
                       input logic [15:0] s_wd, input logic [1:0] s_be,
                       input logic s_re, input logic [3:0] s_ra);
      clr = s_clr; we = s_we; wa = s_wa; wd = s_wd; be = s_be; re = s_re; ra = s_ra;
      @(posedge clk);
      model_edge(s_clr, s_we, s_wa, s_wd, s_be, s_re, s_ra);
      #1;
      model_check();
      $display("cyc %0d clr=%b we=%b wa=%0d wd=%h be=%b re=%b ra=%0d | A v=%b d=%h | B v=%b d=%h | busy=%b",
               cyc, s_clr, s_we, s_wa, s_wd, s_be, s_re, s_ra,
               a_valid, a_data, b_valid, b_data, a_busy);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0);
   endtask

   // Counts cycles with o_Busy high, starting from the current sample.
   task automatic measure_busy(output int n);
      n = 0;
      while (a_busy && n < 40) begin
         n++;
         idle();
      end
   endtask

   // ---------------------------------------------------------------------------
   // Directed vector table (expected values after the edge of each row)
   // ---------------------------------------------------------------------------
   typedef struct {
      logic        clr;
      logic        we;
      logic [3:0]  wa;
      logic [15:0] wd;
      logic [1:0]  be;
      logic        re;
      logic [3:0]  ra;
      logic        va;
      logic [15:0] da;
      logic        vb;
      logic [15:0] db;
      logic        busy;
   } vec_t;

   vec_t vecs [13];

   initial begin
      int n;

      //             clr  we  wa      wd        be     re  ra      va  da        vb  db        busy
      vecs[0]  = '{1'b0,1'b1,4'd3,16'h1234,2'b11,1'b0,4'd0, 1'b0,16'hA5A5,1'b0,16'hA5A5,1'b0};
      vecs[1]  = '{1'b0,1'b0,4'd0,16'h0000,2'b00,1'b1,4'd3, 1'b1,16'h1234,1'b0,16'hA5A5,1'b0};
      vecs[2]  = '{1'b0,1'b0,4'd0,16'h0000,2'b00,1'b0,4'd0, 1'b0,16'h1234,1'b1,16'h1234,1'b0};
      vecs[3]  = '{1'b0,1'b1,4'd5,16'hFFFF,2'b11,1'b0,4'd0, 1'b0,16'h1234,1'b0,16'h1234,1'b0};
      vecs[4]  = '{1'b0,1'b1,4'd5,16'h00AB,2'b01,1'b0,4'd0, 1'b0,16'h1234,1'b0,16'h1234,1'b0};
      vecs[5]  = '{1'b0,1'b1,4'd5,16'h0000,2'b00,1'b1,4'd5, 1'b1,16'hFFAB,1'b0,16'h1234,1'b0};
      vecs[6]  = '{1'b0,1'b0,4'd0,16'h0000,2'b00,1'b1,4'd5, 1'b1,16'hFFAB,1'b1,16'hFFAB,1'b0};
      vecs[7]  = '{1'b0,1'b1,4'd7,16'h1111,2'b11,1'b0,4'd0, 1'b0,16'hFFAB,1'b1,16'hFFAB,1'b0};
      vecs[8]  = '{1'b0,1'b1,4'd7,16'h2222,2'b10,1'b1,4'd7, 1'b1,16'h1111,1'b0,16'hFFAB,1'b0};
      vecs[9]  = '{1'b0,1'b0,4'd0,16'h0000,2'b00,1'b1,4'd7, 1'b1,16'h2211,1'b1,16'h2211,1'b0};
      vecs[10] = '{1'b0,1'b0,4'd0,16'h0000,2'b00,1'b0,4'd0, 1'b0,16'h2211,1'b1,16'h2211,1'b0};
      vecs[11] = '{1'b0,1'b0,4'd0,16'h0000,2'b00,1'b0,4'd0, 1'b0,16'h2211,1'b0,16'h2211,1'b0};
      vecs[12] = '{1'b1,1'b1,4'd2,16'h5555,2'b11,1'b0,4'd0, 1'b0,16'h2211,1'b0,16'h2211,1'b1};

      // ---- Reset state -------------------------------------------------------
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_data_a",  32'(a_data),  32'h0);
      check("reset_valid_a", 32'(a_valid), 32'h0);
      check("reset_data_b",  32'(b_data),  32'h0);
      check("reset_valid_b", 32'(b_valid), 32'h0);
      check("reset_busy",    32'(a_busy),  32'h1);
      rst = 1'b0;

      // ---- Initial clear takes exactly DEPTH cycles ---------------------------
      measure_busy(n);
      check("init_busy_cycles", 32'(n), 32'(DEPTH));

      // ---- Every word reads back as CLEAR_VALUE -------------------------------
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'(i));
         check("clear_read_valid_a", 32'(a_valid), 32'h1);
         check("clear_read_data_a",  32'(a_data),  32'(CV));
      end
      idle();
      idle();

      // ---- Vector table -------------------------------------------------------
      for (int i = 0; i < 13; i++) begin
         step(vecs[i].clr, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be,
              vecs[i].re, vecs[i].ra);
         check("vec_valid_a", 32'(a_valid), 32'(vecs[i].va));
         check("vec_data_a",  32'(a_data),  32'(vecs[i].da));
         check("vec_valid_b", 32'(b_valid), 32'(vecs[i].vb));
         check("vec_data_b",  32'(b_data),  32'(vecs[i].db));
         check("vec_busy",    32'(a_busy),  32'(vecs[i].busy));
      end

      // ---- Clear in progress: writes and reads are ignored ---------------------
      n = 0;
      while (a_busy && n < 40) begin
         n++;
         step(1'b0, 1'b1, 4'd2, 16'h0000, 2'b11, 1'b1, 4'($urandom_range(0, 15)));
         check("busy_no_valid", 32'(a_valid | b_valid), 32'h0);
      end
      check("clear_busy_cycles", 32'(n), 32'(DEPTH));
      step(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd2);
      check("after_clear_a", 32'(a_data), 32'(CV));
      idle();
      check("after_clear_b_valid", 32'(b_valid), 32'h1);
      check("after_clear_b",       32'(b_data),  32'(CV));

      // ---- Reset during a clear with a read in flight --------------------------
      step(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5);
      check("pre_reset_valid_a", 32'(a_valid), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("async_valid_a", 32'(a_valid), 32'h0);
      check("async_data_a",  32'(a_data),  32'h0);
      check("async_valid_b", 32'(b_valid), 32'h0);
      check("async_data_b",  32'(b_data),  32'h0);
      check("async_busy",    32'(a_busy),  32'h1);
      clr = 1'b0;
      re  = 1'b0;
      @(posedge clk);
      #1;
      check("dropped_valid_b", 32'(b_valid), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      measure_busy(n);
      check("restart_busy_cycles", 32'(n), 32'(DEPTH));

      // ---- Randomized traffic against the model --------------------------------
      for (int i = 0; i < 250; i++) begin
         step(($urandom_range(0, 59) == 0),
              1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)),
              16'($urandom_range(0, 65535)),
              2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)));
      end
      for (int i = 0; i < 3; i++) idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
